lcd_timing_rx: RTL and testbench
================================

// Module: lcd_timing_rx
// PURPOSE
//   Receive side of the LCD panel timing interface. Takes a parallel pixel stream
//   (hsync/vsync active-low, data_en active-high, 8-bit data) in the pixel clock domain.
//   Recovers pixel coordinates and measures frame geometry.
//   Declares lock once geometry is stable, and flags timing errors.
//   Sits behind the LVDS deserialiser; feeds capture/loopback checking of the panel driver.
// PARAMETERS
//   CW          12  width of all counters and measured values
//   LOCK_FRAMES 2   consecutive identical frames required to assert locked (1..15)
//   DW          8   pixel data width
// PORTS
//   lvds_parallel_clk in  1   pixel clock; all logic on rising edge
//   rst             in  1   asynchronous, active-high reset
//   hsync_in        in  1   line sync, active low; falling edge = start of line
//   vsync_in        in  1   frame sync, active low; falling edge = start of frame
//   de_in           in  1   data enable, high during active pixels
//   pix_in          in  DW  pixel data, qualified by de_in
//   pix_valid       out 1   pix_out/pix_x/pix_y valid this cycle
//   pix_out         out DW  pixel data, delayed
//   pix_x           out CW  column within active line, 0-based
//   pix_y           out CW  active line within frame, 0-based
//   sof             out 1   1-cycle pulse with first active pixel of frame
//   h_total         out CW  measured clocks per line (hsync fall to hsync fall)
//   h_active        out CW  measured de-high clocks per line
//   v_active        out CW  measured de-active lines per frame
//   locked          out 1   geometry stable
//   frame_err       out 1   sticky; set on geometry mismatch while locked; cleared only by rst
// BEHAVIOUR
//   - Input stage: all inputs registered once (s1), then edges detected vs. previous (s2).
//     - pix_valid/pix_out/pix_x/pix_y/sof are registered from s2.
//     - Fixed latency: de_in/pix_in sampled at edge N appear at outputs after edge N+2.
//   - Reset values: all outputs 0. State = SEARCH. All counters and captured values 0.
//   - pix_x: 0 on first de-high cycle of a line; +1 per further de-high cycle.
//   - pix_y: 0 for first active line after vsync fall; +1 at each de falling edge.
//   - sof: 1 when pix_valid && pix_x==0 && pix_y==0.
//   - hc counts clocks since last hsync fall. At next hsync fall, hc+1 is captured as line_total
//     and hc restarts at 0. A de fall in the same cycle is processed first.
//   - de_len counts de-high cycles. Captured at de fall as line_act.
//     - The first line_act of a frame is the frame reference.
//     - Any later line with a different line_act marks the frame bad.
//   - line count increments at each de fall. At vsync fall it is captured with the frame
//     reference and latest line_total as the candidate (T, A, V); line count then clears.
//   - Counters saturate at 2^CW-1 and do not wrap. A saturated counter marks the frame bad.
//   - FSM, evaluated at each vsync fall:
//     - SEARCH: discard the partial first frame and go to MEASURE; match_cnt=0.
//     - MEASURE, frame bad or candidate differs from previous candidate:
//       match_cnt=0, stay in MEASURE.
//     - MEASURE, otherwise: match_cnt+1. On reaching LOCK_FRAMES-1, enter LOCKED:
//       h_total/h_active/v_active <= candidate, locked=1.
//     - LOCKED, frame bad or candidate differs from outputs: frame_err=1, locked=0,
//       match_cnt=0, go to MEASURE. Outputs keep their last locked values.
//   - de high with vsync low, or de high before the first hsync after reset:
//     data still passes through; the frame is marked bad.
//   - Reset mid-frame returns to SEARCH. The next complete frame is measured from scratch.
//   - h_total/h_active/v_active change only on entry to LOCKED.
// TESTING
//   T1 Reset: rst=1 mid-stream -> all outputs 0 within the same cycle, no pix_valid while rst held.
//   T2 Lock, LOCK_FRAMES=2, line 32 clk (hsync 4, back 4, active 16, front 8),
//      frame 14 lines (vsync 2, back 2, active 8, front 2):
//      -> locked rises at the vsync fall closing the 3rd frame; h_total=32, h_active=16, v_active=8.
//   T3 Coordinates: during a locked frame -> pix_x runs 0..15 per line, pix_y 0..7.
//      sof exactly once per frame; pix_out equals pix_in delayed 2 clocks.
//   T4 Line-width glitch: line 5 of a locked frame has de high 15 clk
//      -> frame_err=1 and locked=0 at that frame's closing vsync fall.
//      Relock after 2 good frames; frame_err stays 1.
//   T5 Geometry change: switch to h_active=20 while locked -> unlock at first changed frame.
//      Relock with h_active=20 after LOCK_FRAMES matching frames.
//   T6 Edge cases: de_in never high -> never locks (frame bad: no reference).
//      hsync stuck high -> hc saturates at 4095, no lock.

Source files
------------

// File: rtl/lcd_timing_rx_if.sv
// Pixel-stream bus between the LVDS deserialiser side and the timing receiver.
// The slave side is the receiver: it consumes sync/data and produces recovered
// coordinates plus the measured geometry. The master side is whoever drives the stream.
interface lcd_timing_rx_if #(
  parameter int CW = 12,
  parameter int DW = 8
);
  // Incoming panel timing stream
  logic          hsync_in;
  logic          vsync_in;
  logic          de_in;
  logic [DW-1:0] pix_in;

  // Recovered pixel stream
  logic          pix_valid;
  logic [DW-1:0] pix_out;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic          sof;

  // Measured geometry and status
  logic [CW-1:0] h_total;
  logic [CW-1:0] h_active;
  logic [CW-1:0] v_active;
  logic          locked;
  logic          frame_err;

  modport slave (
    input  hsync_in, vsync_in, de_in, pix_in,
    output pix_valid, pix_out, pix_x, pix_y, sof,
    output h_total, h_active, v_active, locked, frame_err
  );

  modport master (
    output hsync_in, vsync_in, de_in, pix_in,
    input  pix_valid, pix_out, pix_x, pix_y, sof,
    input  h_total, h_active, v_active, locked, frame_err
  );
endinterface

// File: rtl/lcd_timing_rx.sv
// LCD panel timing receiver.
// Registers the incoming sync/data stream, recovers per-pixel coordinates with a
// fixed two-clock latency, measures line/frame geometry and declares lock once
// LOCK_FRAMES consecutive good frames agree. Any geometry change or malformed
// frame while locked drops lock and sets a sticky error flag.
module lcd_timing_rx #(
  parameter int CW          = 12,
  parameter int LOCK_FRAMES = 2,
  parameter int DW          = 8
) (
  input  logic           lvds_parallel_clk,
  input  logic           rst,
  lcd_timing_rx_if.slave bus
);

  localparam logic [CW-1:0] CMAX = {CW{1'b1}};
  localparam logic [CW-1:0] CONE = CW'(1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input stage: s1 is the registered input, s2 the previous s1 for edge detect
  // ---------------------------------------------------------------------------
  logic          hs_s1_q, vs_s1_q, de_s1_q;
  logic [DW-1:0] pix_s1_q;
  logic          hs_s2_q, vs_s2_q, de_s2_q;
  logic [DW-1:0] pix_s2_q;

  // Two-deep input pipeline; sync regs reset low so no edge is seen during reset
  always_ff @(posedge lvds_parallel_clk or posedge rst) begin
    if (rst) begin
      hs_s1_q  <= 1'b0;
      vs_s1_q  <= 1'b0;
      de_s1_q  <= 1'b0;
      pix_s1_q <= '0;
      hs_s2_q  <= 1'b0;
      vs_s2_q  <= 1'b0;
      de_s2_q  <= 1'b0;
      pix_s2_q <= '0;
    end else begin
      hs_s1_q  <= bus.hsync_in;
      vs_s1_q  <= bus.vsync_in;
      de_s1_q  <= bus.de_in;
      pix_s1_q <= bus.pix_in;
      hs_s2_q  <= hs_s1_q;
      vs_s2_q  <= vs_s1_q;
      de_s2_q  <= de_s1_q;
      pix_s2_q <= pix_s1_q;
    end
  end

  logic hs_fall, vs_fall, de_rise, de_fall;
  assign hs_fall = hs_s2_q & ~hs_s1_q;
  assign vs_fall = vs_s2_q & ~vs_s1_q;
  assign de_rise = de_s1_q & ~de_s2_q;
  assign de_fall = de_s2_q & ~de_s1_q;

  // ---------------------------------------------------------------------------
  // Geometry measurement counters
  // ---------------------------------------------------------------------------
  logic [CW-1:0] hc_q, hc_d;                  // clocks since last hsync fall
  logic [CW-1:0] line_total_q, line_total_d;  // last complete line length
  logic [CW-1:0] de_len_q, de_len_d;          // de-high run length of current line
  logic [CW-1:0] ref_act_q, ref_act_d;        // first line_act of the frame
  logic          ref_valid_q, ref_valid_d;
  logic [CW-1:0] lc_q, lc_d;                  // active lines seen this frame
  logic [CW-1:0] y_cnt_q, y_cnt_d;            // active line index used for pix_y
  logic          seen_hs_q, seen_hs_d;        // an hsync fall has occurred since reset
  logic          bad_q, bad_d;                // current frame is malformed
  logic          bad_set;
  logic          frame_bad;
  logic [CW-1:0] cand_t, cand_a, cand_v;

  // Counter updates and per-frame candidate extraction; the candidate is taken
  // before the vsync-fall clear so same-cycle line events belong to the closing frame
  always_comb begin
    hc_d         = hc_q;
    line_total_d = line_total_q;
    de_len_d     = de_len_q;
    ref_act_d    = ref_act_q;
    ref_valid_d  = ref_valid_q;
    lc_d         = lc_q;
    y_cnt_d      = y_cnt_q;
    seen_hs_d    = seen_hs_q;
    bad_set      = 1'b0;

    // Line length: capture hc+1 at hsync fall, otherwise count up and stick at max
    if (hs_fall) begin
      line_total_d = (hc_q == CMAX) ? CMAX : hc_q + CONE;
      hc_d         = '0;
      seen_hs_d    = 1'b1;
    end else if (hc_q != CMAX) begin
      hc_d = hc_q + CONE;
    end
    if (hc_q == CMAX) begin
      bad_set = 1'b1;
    end

    // Active run length
    if (de_rise) begin
      de_len_d = CONE;
    end else if (de_s1_q && de_s2_q) begin
      if (de_len_q == CMAX) begin
        bad_set = 1'b1;
      end else begin
        de_len_d = de_len_q + CONE;
      end
    end

    // End of an active line: first one sets the reference, later ones must match
    if (de_fall) begin
      if (!ref_valid_q) begin
        ref_act_d   = de_len_q;
        ref_valid_d = 1'b1;
      end else if (de_len_q != ref_act_q) begin
        bad_set = 1'b1;
      end
      if (lc_q == CMAX) begin
        bad_set = 1'b1;
      end else begin
        lc_d = lc_q + CONE;
      end
      if (y_cnt_q != CMAX) begin
        y_cnt_d = y_cnt_q + CONE;
      end
    end

    // Data during vertical sync, or before any line timing exists, is not trustworthy
    if (de_s1_q && (!vs_s1_q || !seen_hs_q)) begin
      bad_set = 1'b1;
    end

    bad_d     = bad_q | bad_set;
    frame_bad = bad_d | ~ref_valid_d;
    cand_t    = line_total_d;
    cand_a    = ref_act_d;
    cand_v    = lc_d;

    // New frame starts: clear per-frame state
    if (vs_fall) begin
      lc_d        = '0;
      ref_act_d   = '0;
      ref_valid_d = 1'b0;
      bad_d       = 1'b0;
      y_cnt_d     = '0;
    end
  end

  // Measurement state registers
  always_ff @(posedge lvds_parallel_clk or posedge rst) begin
    if (rst) begin
      hc_q         <= '0;
      line_total_q <= '0;
      de_len_q     <= '0;
      ref_act_q    <= '0;
      ref_valid_q  <= 1'b0;
      lc_q         <= '0;
      y_cnt_q      <= '0;
      seen_hs_q    <= 1'b0;
      bad_q        <= 1'b0;
    end else begin
      hc_q         <= hc_d;
      line_total_q <= line_total_d;
      de_len_q     <= de_len_d;
      ref_act_q    <= ref_act_d;
      ref_valid_q  <= ref_valid_d;
      lc_q         <= lc_d;
      y_cnt_q      <= y_cnt_d;
      seen_hs_q    <= seen_hs_d;
      bad_q        <= bad_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel output stage (registered from s2)
  // ---------------------------------------------------------------------------
  logic          pix_valid_q, pix_valid_d;
  logic [DW-1:0] pix_out_q, pix_out_d;
  logic [CW-1:0] pix_x_q, pix_x_d;
  logic [CW-1:0] pix_y_q, pix_y_d;
  logic          sof_q, sof_d;

  // Coordinates: the previous output valid doubles as "previous de" for the column
  // restart; y_cnt already reflects every line end older than the s2 sample
  always_comb begin
    pix_valid_d = de_s2_q;
    pix_out_d   = pix_s2_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    sof_d       = 1'b0;
    if (de_s2_q) begin
      if (pix_valid_q) begin
        pix_x_d = (pix_x_q == CMAX) ? CMAX : pix_x_q + CONE;
      end else begin
        pix_x_d = '0;
      end
      pix_y_d = y_cnt_q;
      sof_d   = !pix_valid_q && (y_cnt_q == '0);
    end
  end

  // Output pixel registers
  always_ff @(posedge lvds_parallel_clk or posedge rst) begin
    if (rst) begin
      pix_valid_q <= 1'b0;
      pix_out_q   <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      sof_q       <= 1'b0;
    end else begin
      pix_valid_q <= pix_valid_d;
      pix_out_q   <= pix_out_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      sof_q       <= sof_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM, advanced only at vsync fall
  // ---------------------------------------------------------------------------
  state_t        state_q;
  logic [3:0]    match_cnt_q;
  logic [CW-1:0] prev_t_q, prev_a_q, prev_v_q;
  logic          prev_valid_q;
  logic [CW-1:0] h_total_q, h_active_q, v_active_q;
  logic          locked_q, frame_err_q;

  logic       cand_eq_prev, cand_eq_out, lock_now;
  logic [3:0] match_next;

  assign cand_eq_prev = prev_valid_q && (cand_t == prev_t_q) &&
                        (cand_a == prev_a_q) && (cand_v == prev_v_q);
  assign cand_eq_out  = (cand_t == h_total_q) && (cand_a == h_active_q) &&
                        (cand_v == v_active_q);
  assign match_next   = match_cnt_q + 4'd1;
  assign lock_now     = (LOCK_FRAMES <= 1) ||
                        (cand_eq_prev && (int'(match_next) >= LOCK_FRAMES - 1));

  // A bad frame never serves as a comparison reference, so recovery from a
  // glitch always needs a full run of fresh good frames
  always_ff @(posedge lvds_parallel_clk or posedge rst) begin
    if (rst) begin
      state_q      <= SEARCH;
      match_cnt_q  <= '0;
      prev_t_q     <= '0;
      prev_a_q     <= '0;
      prev_v_q     <= '0;
      prev_valid_q <= 1'b0;
      h_total_q    <= '0;
      h_active_q   <= '0;
      v_active_q   <= '0;
      locked_q     <= 1'b0;
      frame_err_q  <= 1'b0;
    end else if (vs_fall) begin
      case (state_q)
        SEARCH: begin
          state_q      <= MEASURE;
          match_cnt_q  <= '0;
          prev_valid_q <= 1'b0;
        end
        MEASURE: begin
          if (frame_bad) begin
            match_cnt_q  <= '0;
            prev_valid_q <= 1'b0;
          end else begin
            prev_t_q     <= cand_t;
            prev_a_q     <= cand_a;
            prev_v_q     <= cand_v;
            prev_valid_q <= 1'b1;
            if (lock_now) begin
              state_q     <= LOCKED;
              locked_q    <= 1'b1;
              h_total_q   <= cand_t;
              h_active_q  <= cand_a;
              v_active_q  <= cand_v;
              match_cnt_q <= '0;
            end else if (cand_eq_prev) begin
              match_cnt_q <= match_next;
            end else begin
              match_cnt_q <= '0;
            end
          end
        end
        LOCKED: begin
          if (frame_bad || !cand_eq_out) begin
            state_q      <= MEASURE;
            locked_q     <= 1'b0;
            frame_err_q  <= 1'b1;
            match_cnt_q  <= '0;
            prev_t_q     <= cand_t;
            prev_a_q     <= cand_a;
            prev_v_q     <= cand_v;
            prev_valid_q <= !frame_bad;
          end
        end
        default: begin
          state_q <= SEARCH;
        end
      endcase
    end
  end

  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_out   = pix_out_q;
  assign bus.pix_x     = pix_x_q;
  assign bus.pix_y     = pix_y_q;
  assign bus.sof       = sof_q;
  assign bus.h_total   = h_total_q;
  assign bus.h_active  = h_active_q;
  assign bus.v_active  = v_active_q;
  assign bus.locked    = locked_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_lcd_timing_rx.sv
// Bench for lcd_timing_rx: a table of frames (geometry, glitches, resets) with the
// status expected at the start of each frame, plus a pixel scoreboard that
// checks data, coordinates, sof and the fixed two-clock latency.
module tb_lcd_timing_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_timing_rx_if #(.CW(12), .DW(8)) bus ();

  lcd_timing_rx #(.CW(12), .LOCK_FRAMES(2), .DW(8)) dut (
    .lvds_parallel_clk (clk),
    .rst               (rst),
    .bus               (bus)
  );

  int n_asrt = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] pix;
    int         x;
    int         y;
    logic       sof;
    int         cyc;
  } pix_t;

  pix_t sb_q[$];
  pix_t mon_e;

  // One frame of stimulus plus the status expected once the previous frame closed
  typedef struct {
    bit rb;      // pulse reset before this frame
    int aw;      // active width
    int gw;      // width of active line 5 (0 = same as aw)
    bit de_off;  // de never asserted
    bit hs_st;   // hsync stuck high
    int ab;      // active line at which reset is asserted mid-frame (-1 = none)
    bit lk;
    bit er;
    int ht;
    int ha;
    int va;
  } frame_rec_t;

  frame_rec_t tbl[27];

  function automatic frame_rec_t rec(bit rb, int aw, int gw, bit de_off, bit hs_st, int ab,
                                     bit lk, bit er, int ht, int ha, int va);
    frame_rec_t r;
    r.rb = rb; r.aw = aw; r.gw = gw; r.de_off = de_off; r.hs_st = hs_st; r.ab = ab;
    r.lk = lk; r.er = er; r.ht = ht; r.ha = ha; r.va = va;
    return r;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic any_out();
    return bus.pix_valid | bus.sof | (|bus.pix_out) | (|bus.pix_x) | (|bus.pix_y) |
           (|bus.h_total) | (|bus.h_active) | (|bus.v_active) | bus.locked | bus.frame_err;
  endfunction

  // Scoreboard: pop one expected pixel per valid output
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else if (bus.pix_valid) begin
      if (sb_q.size() == 0) begin
        chk("pix_unexpected", 32'(bus.pix_valid), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("pix_latency", 32'(cyc), 32'(mon_e.cyc));
        chk("pix_out", 32'(bus.pix_out), 32'(mon_e.pix));
        chk("pix_x", 32'(bus.pix_x), 32'(mon_e.x));
        chk("pix_y", 32'(bus.pix_y), 32'(mon_e.y));
        chk("sof", 32'(bus.sof), 32'(mon_e.sof));
      end
    end else if (bus.sof) begin
      chk("sof_without_valid", 32'(bus.sof), 32'd0);
    end
  end

  task automatic set_idle();
    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b1;
    bus.de_in    = 1'b0;
    bus.pix_in   = 8'h00;
  endtask

  task automatic step(input logic hs, input logic vs, input logic de, input int x, input int y);
    pix_t e;
    @(negedge clk);
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    bus.de_in    = de;
    bus.pix_in   = 8'($urandom);
    if (de) begin
      e.pix = bus.pix_in;
      e.x   = x;
      e.y   = y;
      e.sof = (x == 0) && (y == 0);
      e.cyc = cyc + 3;
      sb_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    #1;
    chk("reset_outputs_zero", 32'(any_out()), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Reset asserted in the middle of an active line: outputs clear at once and stay quiet
  task automatic mid_frame_reset();
    @(negedge clk);
    chk("pre_reset_valid", 32'(bus.pix_valid), 32'd1);
    rst = 1'b1;
    set_idle();
    #1;
    chk("async_reset_outputs_zero", 32'(any_out()), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("valid_during_reset", 32'(bus.pix_valid), 32'd0);
    end
    rst = 1'b0;
  endtask

  // 32-clock lines (hsync 4, back 4, active aw, front rest); 14-line frames
  // (vsync 2, back 2, active 8, front 2)
  task automatic run_frame(input int idx, input frame_rec_t r);
    logic hs, vs, de;
    int   w;
    for (int ln = 0; ln < 14; ln++) begin
      w = (ln - 4 == 5 && r.gw > 0) ? r.gw : r.aw;
      for (int col = 0; col < 32; col++) begin
        if (r.ab >= 0 && ln - 4 == r.ab && col == 12) begin
          mid_frame_reset();
          return;
        end
        hs = r.hs_st ? 1'b1 : (col >= 4);
        vs = (ln >= 2);
        de = !r.de_off && (ln >= 4) && (ln < 12) && (col >= 8) && (col < 8 + w);
        step(hs, vs, de, col - 8, ln - 4);
        if (ln == 0 && col == 5) begin
          chk("locked", 32'(bus.locked), 32'(r.lk));
          chk("frame_err", 32'(bus.frame_err), 32'(r.er));
          chk("h_total", 32'(bus.h_total), 32'(r.ht));
          chk("h_active", 32'(bus.h_active), 32'(r.ha));
          chk("v_active", 32'(bus.v_active), 32'(r.va));
          $display("frame %0d: locked=%0d frame_err=%0d h_total=%0d h_active=%0d v_active=%0d",
                   idx, bus.locked, bus.frame_err, bus.h_total, bus.h_active, bus.v_active);
        end
      end
    end
  endtask

  initial begin
    set_idle();
    //            rb aw  gw de hs ab  lk er ht  ha  va
    tbl[0]  = rec(1, 16, 0, 0, 0, -1, 0, 0, 0,  0,  0);
    tbl[1]  = rec(0, 16, 0, 0, 0, -1, 0, 0, 0,  0,  0);
    tbl[2]  = rec(0, 16, 0, 0, 0, -1, 1, 0, 32, 16, 8);
    tbl[3]  = rec(0, 16, 15, 0, 0, -1, 1, 0, 32, 16, 8);
    tbl[4]  = rec(0, 16, 0, 0, 0, -1, 0, 1, 32, 16, 8);
    tbl[5]  = rec(0, 16, 0, 0, 0, -1, 0, 1, 32, 16, 8);
    tbl[6]  = rec(0, 16, 0, 0, 0, -1, 1, 1, 32, 16, 8);
    tbl[7]  = rec(0, 20, 0, 0, 0, -1, 1, 1, 32, 16, 8);
    tbl[8]  = rec(0, 20, 0, 0, 0, -1, 0, 1, 32, 16, 8);
    tbl[9]  = rec(0, 20, 0, 0, 0, -1, 1, 1, 32, 20, 8);
    tbl[10] = rec(0, 20, 0, 0, 0, 2,  1, 1, 32, 20, 8);
    tbl[11] = rec(1, 16, 0, 1, 0, -1, 0, 0, 0,  0,  0);
    for (int i = 12; i < 15; i++) tbl[i] = rec(0, 16, 0, 1, 0, -1, 0, 0, 0, 0, 0);
    tbl[15] = rec(1, 16, 0, 0, 1, -1, 0, 0, 0,  0,  0);
    for (int i = 16; i < 27; i++) tbl[i] = rec(0, 16, 0, 0, 1, -1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 27; i++) begin
      if (tbl[i].rb) do_reset();
      run_frame(i, tbl[i]);
    end

    set_idle();
    repeat (6) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    chk("final_locked", 32'(bus.locked), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
